// File: rtl/dpram_types_pkg.sv
// dpram_types_pkg
//   Shared definitions for the byte-enable dual-port RAM and its init sweep.
//   Provides default geometry, the byte size, the INIT/RUN state encoding and
//   the even-parity helper used when parity storage is compiled in
//   (DPRAM_PARITY_EN).
package dpram_types_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int BYTE       = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dpram_state_t;

  // Even parity: the returned bit makes the total number of ones in
  // {byte, parity} even, so an all-zero byte carries a zero parity bit.
  function automatic logic even_par(input logic [BYTE-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// dpram_init_ctrl
//   Post-reset clearing sequencer for the dual-port RAM. After reset it walks
//   init_ptr from 0 to DEPTH-1, requesting one zero-write per cycle, then
//   parks in RUN and raises init_done until the next reset.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset, restarts the sweep at 0
//   init_we    out  write strobe for the clearing write (high throughout INIT)
//   init_addr  out  word address being cleared this cycle
//   init_done  out  high once every word has been cleared
module dpram_init_ctrl
  import dpram_types_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done
);

  dpram_state_t      state;
  dpram_state_t      state_nxt;
  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] init_ptr_nxt;

  // State and sweep pointer. Any reset, whether mid-sweep or in RUN,
  // returns to INIT with the pointer at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state    <= state_nxt;
      init_ptr <= init_ptr_nxt;
    end
  end

  // One word is cleared per cycle while in INIT. The cycle that clears the
  // last word (pointer all ones) also moves to RUN, so init_done appears
  // exactly DEPTH clock edges after reset is released.
  always_comb begin
    state_nxt    = state;
    init_ptr_nxt = init_ptr;
    init_we      = 1'b0;
    init_done    = 1'b0;
    case (state)
      INIT: begin
        init_we      = 1'b1;
        init_ptr_nxt = init_ptr + 1'b1;
        if (init_ptr == {ADDR_W{1'b1}}) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
      end
    endcase
  end

  assign init_addr = init_ptr;

endmodule

// File: rtl/dpram_be_init.sv
// dpram_be_init
//   Parametrised true dual-port RAM with per-byte write enables, a selectable
//   read latency (RD_LAT = 1 or 2) and an automatic clearing sweep after
//   reset. Both ports share one clock and are ignored until init_done is high.
//   Optional feature macro: DPRAM_PARITY_EN adds one even-parity bit per byte,
//   the a_perr/b_perr outputs and the flip_bit corruption task.
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   init_done           high once every word has been cleared
//   a_req / b_req       request strobe, honoured only when init_done is high
//   a_we / b_we         1 = write, 0 = read
//   a_addr / b_addr     word address
//   a_wdata / b_wdata   write data
//   a_be / b_be         byte enables, bit i covers data bits 8i+7:8i
//   a_rvalid / b_rvalid one-cycle pulse RD_LAT cycles after a read request
//   a_rdata / b_rdata   read data, held until the next read completes
//   a_perr / b_perr     parity mismatch flag alongside rvalid (parity build)
module dpram_be_init
  import dpram_types_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   init_done,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_wdata,
  input  logic [DATA_W/BYTE-1:0] a_be,
  output logic                   a_rvalid,
  output logic [DATA_W-1:0]      a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_wdata,
  input  logic [DATA_W/BYTE-1:0] b_be,
  output logic                   b_rvalid,
  output logic [DATA_W-1:0]      b_rdata
`ifdef DPRAM_PARITY_EN
  ,
  output logic                   a_perr,
  output logic                   b_perr
`endif
);

  localparam int BE_W  = DATA_W / BYTE;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [BE_W-1:0]   be_t;
  typedef logic [ADDR_W-1:0] addr_t;

  logic  init_we;
  addr_t init_addr;

  logic  wa_en;
  addr_t wa_addr;
  word_t wa_data;
  be_t   wa_be;
  logic  wb_en;

  logic  [1:0] rd_acc;
  addr_t       rd_addr [2];

  word_t mem_data [DEPTH];
`ifdef DPRAM_PARITY_EN
  be_t   mem_par  [DEPTH];

  // True when any stored parity bit disagrees with its byte.
  function automatic logic par_err(input word_t d, input be_t p);
    logic e;
    e = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      e = e | (even_par(d[i*BYTE +: BYTE]) != p[i]);
    end
    return e;
  endfunction

  // Corrupts one stored data bit without touching its parity, so the next
  // read of that word reports a parity error.
  task automatic flip_bit(input addr_t addr, input int bit_idx);
    mem_data[addr][bit_idx] = ~mem_data[addr][bit_idx];
  endtask
`endif

  dpram_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  // Port A's write path doubles as the clearing path. During the sweep it
  // carries a full-word zero write to the sweep address and user requests
  // are dropped; afterwards it carries port A's own writes.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = a_addr;
    wa_data = a_wdata;
    wa_be   = a_be;
    if (!init_done) begin
      wa_en   = init_we;
      wa_addr = init_addr;
      wa_data = '0;
      wa_be   = '1;
    end else begin
      wa_en   = a_req & a_we;
    end
  end

  assign wb_en      = init_done & b_req & b_we;
  assign rd_acc[0]  = init_done & a_req & ~a_we;
  assign rd_acc[1]  = init_done & b_req & ~b_we;
  assign rd_addr[0] = a_addr;
  assign rd_addr[1] = b_addr;

  // Array writes. Port B is applied first and port A second; when both hit
  // the same byte of the same word the later non-blocking update (A) wins,
  // while bytes only B enables still take B's data. Reads elsewhere sample
  // the array before these updates land, which gives read-first collisions.
  always_ff @(posedge clk) begin
    if (wb_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (b_be[i]) begin
          mem_data[b_addr][i*BYTE +: BYTE] <= b_wdata[i*BYTE +: BYTE];
`ifdef DPRAM_PARITY_EN
          mem_par[b_addr][i] <= even_par(b_wdata[i*BYTE +: BYTE]);
`endif
        end
      end
    end
    if (wa_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wa_be[i]) begin
          mem_data[wa_addr][i*BYTE +: BYTE] <= wa_data[i*BYTE +: BYTE];
`ifdef DPRAM_PARITY_EN
          mem_par[wa_addr][i] <= even_par(wa_data[i*BYTE +: BYTE]);
`endif
        end
      end
    end
  end

  // Identical read pipeline for each port: index 0 is A, index 1 is B.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic  s1_valid;
    word_t s1_data;
    logic  out_valid;
    word_t out_data;
`ifdef DPRAM_PARITY_EN
    logic  s1_perr;
    logic  out_perr;
`endif

    // First read stage: captures the addressed word on an accepted read.
    // The data register only moves on a read so the last word stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
`ifdef DPRAM_PARITY_EN
        s1_perr  <= 1'b0;
`endif
      end else begin
        s1_valid <= rd_acc[p];
        if (rd_acc[p]) begin
          s1_data <= mem_data[rd_addr[p]];
        end
`ifdef DPRAM_PARITY_EN
        s1_perr <= rd_acc[p] & par_err(mem_data[rd_addr[p]], mem_par[rd_addr[p]]);
`endif
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      // Optional output register: delays the valid pulse, data and parity
      // flag by one more cycle, again holding data between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
`ifdef DPRAM_PARITY_EN
          out_perr  <= 1'b0;
`endif
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_data <= s1_data;
          end
`ifdef DPRAM_PARITY_EN
          out_perr <= s1_valid & s1_perr;
`endif
        end
      end
    end else begin : g_lat1
      assign out_valid = s1_valid;
      assign out_data  = s1_data;
`ifdef DPRAM_PARITY_EN
      assign out_perr  = s1_perr;
`endif
    end
  end

  assign a_rvalid = g_port[0].out_valid;
  assign a_rdata  = g_port[0].out_data;
  assign b_rvalid = g_port[1].out_valid;
  assign b_rdata  = g_port[1].out_data;
`ifdef DPRAM_PARITY_EN
  assign a_perr   = g_port[0].out_perr;
  assign b_perr   = g_port[1].out_perr;
`endif

endmodule

// File: tb/tb_dpram_be_init.sv
// tb_dpram_be_init
//   Self-checking bench for dpram_be_init (ADDR_W=8, DATA_W=32). Reads are
//   predicted when driven and queued with the cycle they are due; a monitor
//   compares rvalid/rdata every cycle against the queue heads. Parity checks
//   are compiled in with DPRAM_PARITY_EN.
module tb_dpram_be_init;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 1;

  logic              clk;
  logic              rst_n;
  logic              init_done;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [BE_W-1:0]   a_be, b_be;
  logic              a_rvalid, b_rvalid;
  logic              a_perr_s, b_perr_s;

  dpram_be_init #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_be      (a_be),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_be      (b_be),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata)
`ifdef DPRAM_PARITY_EN
    ,
    .a_perr    (a_perr_s),
    .b_perr    (b_perr_s)
`endif
  );

`ifndef DPRAM_PARITY_EN
  assign a_perr_s = 1'b0;
  assign b_perr_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [31:0] exp_a;
    logic        exp_a_perr;
    logic        b_req;
    logic        b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic [31:0] exp_b;
    logic        exp_b_perr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
  } sb_t;

  sb_t         sb_a [$];
  sb_t         sb_b [$];
  logic [31:0] model [DEPTH];
  vec_t        tbl [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa,
                              input logic [31:0] ad, input logic [3:0] ab, input logic [31:0] ea,
                              input logic br, input logic bw, input logic [7:0] ba,
                              input logic [31:0] bd, input logic [3:0] bb, input logic [31:0] eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_be = ab;
    v.exp_a = ea; v.exp_a_perr = 1'b0;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_be = bb;
    v.exp_b = eb; v.exp_b_perr = 1'b0;
    return v;
  endfunction

  task automatic idleInputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Drives one cycle of requests, queues the expected read results and then
  // applies the writes to the model (B first, A on top) so reads in the same
  // cycle see the old contents.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata; a_be = v.a_be;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata; b_be = v.b_be;
    if (v.a_req && !v.a_we) sb_a.push_back('{data: v.exp_a, perr: v.exp_a_perr, due: cyc + RD_LAT});
    if (v.b_req && !v.b_we) sb_b.push_back('{data: v.exp_b, perr: v.exp_b_perr, due: cyc + RD_LAT});
    for (int i = 0; i < BE_W; i++) begin
      if (v.b_req && v.b_we && v.b_be[i]) model[v.b_addr][i*8 +: 8] = v.b_wdata[i*8 +: 8];
    end
    for (int i = 0; i < BE_W; i++) begin
      if (v.a_req && v.a_we && v.a_be[i]) model[v.a_addr][i*8 +: 8] = v.a_wdata[i*8 +: 8];
    end
  endtask

  task automatic checkOutput(input int port);
    sb_t         head;
    logic        exp_v;
    logic        got_v;
    logic [31:0] got_d;
    logic        got_pe;
    string       pname;
    exp_v = 1'b0;
    head  = '{data: '0, perr: 1'b0, due: 0};
    if (port == 0) begin
      pname = "a"; got_v = a_rvalid; got_d = a_rdata; got_pe = a_perr_s;
      if (sb_a.size() > 0 && sb_a[0].due == cyc) begin exp_v = 1'b1; head = sb_a.pop_front(); end
    end else begin
      pname = "b"; got_v = b_rvalid; got_d = b_rdata; got_pe = b_perr_s;
      if (sb_b.size() > 0 && sb_b[0].due == cyc) begin exp_v = 1'b1; head = sb_b.pop_front(); end
    end
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("[TB] FAIL rvalid_%s cyc=%0d got=%b exp=%b", pname, cyc, got_v, exp_v);
    end
    if (exp_v) begin
      checks++;
      if (got_d !== head.data) begin
        failures++;
        $display("[TB] FAIL rdata_%s cyc=%0d got=%h exp=%h", pname, cyc, got_d, head.data);
      end
`ifdef DPRAM_PARITY_EN
      checks++;
      if (got_pe !== head.perr) begin
        failures++;
        $display("[TB] FAIL perr_%s cyc=%0d got=%b exp=%b", pname, cyc, got_pe, head.perr);
      end
`endif
    end
  endtask

  // Counts clock edges from reset release until init_done; stops driving
  // the ignored init-time requests a few cycles before the sweep ends.
  task automatic waitInit(output int cnt);
    cnt = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 250) idleInputs();
      if (init_done === 1'b1 || cnt >= 1000) break;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      checkOutput(0);
      checkOutput(1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   cnt;
    vec_t v;

    rst_n = 1'b0;
    idleInputs();
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkBit("reset_init_done", init_done, 1'b0);
    checkBit("reset_a_rvalid", a_rvalid, 1'b0);
    checkBit("reset_b_rvalid", b_rvalid, 1'b0);
    checkWord("reset_a_rdata", a_rdata, 32'h0);
    checkWord("reset_b_rdata", b_rdata, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 32'hFFFFFFFF; a_be = 4'hF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05;
    waitInit(cnt);
    checkWord("init_cycles", 32'(cnt), 32'd256);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(mk(1'b1, 1'b0, 8'(i), '0, '0, model[i],
                       1'b1, 1'b0, 8'(255 - i), '0, '0, model[255 - i]));
    end

    tbl.push_back(mk(1,1,8'h10,32'hDEADBEEF,4'hF,32'h0,       0,0,8'h00,32'h0,4'h0,32'h0));
    tbl.push_back(mk(0,0,8'h00,32'h0,4'h0,32'h0,              1,0,8'h10,32'h0,4'h0,32'hDEADBEEF));
    tbl.push_back(mk(1,1,8'h40,32'h11223344,4'hF,32'h0,       0,0,8'h00,32'h0,4'h0,32'h0));
    tbl.push_back(mk(1,1,8'h40,32'hAABBCCDD,4'b0101,32'h0,    0,0,8'h00,32'h0,4'h0,32'h0));
    tbl.push_back(mk(1,0,8'h40,32'h0,4'h0,32'h11BB33DD,       0,0,8'h00,32'h0,4'h0,32'h0));
    tbl.push_back(mk(1,1,8'h20,32'h000000FF,4'b0001,32'h0,    1,1,8'h20,32'hFFFFFF00,4'hF,32'h0));
    tbl.push_back(mk(1,0,8'h20,32'h0,4'h0,32'hFFFFFFFF,       1,0,8'h20,32'h0,4'h0,32'hFFFFFFFF));
    tbl.push_back(mk(1,1,8'h20,32'h12345678,4'hF,32'h0,       1,0,8'h20,32'h0,4'h0,32'hFFFFFFFF));
    tbl.push_back(mk(1,1,8'h50,32'h55555555,4'h0,32'h0,       1,0,8'h20,32'h0,4'h0,32'h12345678));
    tbl.push_back(mk(1,0,8'h50,32'h0,4'h0,32'h0,              1,1,8'h60,32'hCAFEF00D,4'hF,32'h0));
    tbl.push_back(mk(1,0,8'h60,32'h0,4'h0,32'hCAFEF00D,       1,0,8'h10,32'h0,4'h0,32'hDEADBEEF));
    tbl.push_back(mk(1,1,8'h70,32'h0000CD00,4'b0010,32'h0,    1,1,8'h70,32'hAB000000,4'b1000,32'h0));
    tbl.push_back(mk(1,0,8'h70,32'h0,4'h0,32'hAB00CD00,       1,0,8'hFF,32'h0,4'h0,32'h0));
    tbl.push_back(mk(1,0,8'h10,32'h0,4'h0,32'hDEADBEEF,       1,0,8'h05,32'h0,4'h0,32'h0));
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

    repeat (3) applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    @(posedge clk);
    #2;
    checkWord("rdata_hold_a", a_rdata, 32'hDEADBEEF);

    applyStimulus(mk(1,1,8'hC0,32'h0BADF00D,4'hF,32'h0, 0,0,0,0,0,0));
    applyStimulus(mk(1,0,8'hC0,32'h0,4'h0,32'h0BADF00D, 0,0,0,0,0,0));
    applyStimulus(mk(1,0,8'h10,32'h0,4'h0,32'hDEADBEEF, 0,0,0,0,0,0));
    repeat (RD_LAT) begin
      @(posedge clk);
      #2;
      idleInputs();
    end
    checkBit("pre_reset_a_rvalid", a_rvalid, 1'b1);
    rst_n = 1'b0;
    sb_a.delete();
    sb_b.delete();
    resetModel();
    #1;
    checkBit("async_reset_a_rvalid", a_rvalid, 1'b0);
    checkWord("async_reset_a_rdata", a_rdata, 32'h0);
    checkBit("async_reset_init_done", init_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    checkBit("mid_sweep_init_done", init_done, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    waitInit(cnt);
    checkWord("reinit_cycles", 32'(cnt), 32'd256);
    applyStimulus(mk(1,0,8'h10,32'h0,4'h0,32'h0, 1,0,8'hC0,32'h0,4'h0,32'h0));
    applyStimulus(mk(1,0,8'h40,32'h0,4'h0,32'h0, 1,0,8'h70,32'h0,4'h0,32'h0));

    for (int k = 0; k < 200; k++) begin
      v = mk(0,0,0,0,0,0, 0,0,0,0,0,0);
      v.a_req   = 1'($urandom_range(0, 1));
      v.a_we    = 1'($urandom_range(0, 1));
      v.a_addr  = 8'(8'h80 + $urandom_range(0, 7));
      v.a_wdata = $urandom();
      v.a_be    = 4'($urandom_range(0, 15));
      v.b_req   = 1'($urandom_range(0, 1));
      v.b_we    = 1'($urandom_range(0, 1));
      v.b_addr  = 8'(8'h80 + $urandom_range(0, 7));
      v.b_wdata = $urandom();
      v.b_be    = 4'($urandom_range(0, 15));
      v.exp_a   = model[v.a_addr];
      v.exp_b   = model[v.b_addr];
      applyStimulus(v);
    end

`ifdef DPRAM_PARITY_EN
    applyStimulus(mk(1,1,8'h30,32'h12345678,4'hF,32'h0, 0,0,0,0,0,0));
    applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    dut.flip_bit(8'h30, 5);
    model[8'h30][5] = ~model[8'h30][5];
    v = mk(1,0,8'h30,32'h0,4'h0,32'h12345658, 1,0,8'h30,32'h0,4'h0,32'h12345658);
    v.exp_a_perr = 1'b1;
    v.exp_b_perr = 1'b1;
    applyStimulus(v);
    applyStimulus(mk(1,1,8'h30,32'h12345678,4'hF,32'h0, 0,0,0,0,0,0));
    applyStimulus(mk(1,0,8'h30,32'h0,4'h0,32'h12345678, 0,0,0,0,0,0));
`endif

    repeat (RD_LAT + 2) applyStimulus(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    @(posedge clk);
    #2;
    checkWord("scoreboard_drained", 32'(sb_a.size() + sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
